// File: rtl/pc_next_ext_unit_pkg.sv
// Shared fetch-side control encodings.
// Immediate-format and next-PC select codes, also used by the decoder.
package pc_next_ext_unit_pkg;

  localparam logic [5:0] EXT_CTRL_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_CTRL_ITYPE = 6'b010000;
  localparam logic [5:0] EXT_CTRL_STYPE = 6'b001000;
  localparam logic [5:0] EXT_CTRL_BTYPE = 6'b000100;
  localparam logic [5:0] EXT_CTRL_UTYPE = 6'b000010;
  localparam logic [5:0] EXT_CTRL_JTYPE = 6'b000001;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_next_ext_unit_imm_ext.sv
// Immediate generator for RV32I formats.
// One-hot select; highest set bit wins when several are set.
module imm_ext_unit
  import pc_next_ext_unit_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [5:0]  ext_op,
  output logic [31:0] imm_out
);

  logic [4:0]  f_shamt;
  logic [11:0] f_i;
  logic [11:0] f_s;
  logic [11:0] f_b;
  logic [19:0] f_u;
  logic [19:0] f_j;

  assign f_shamt = instr[24:20];
  assign f_i     = instr[31:20];
  assign f_s     = {instr[31:25], instr[11:7]};
  assign f_b     = {instr[31], instr[7],
                    instr[30:25], instr[11:8]};
  assign f_u     = instr[31:12];
  assign f_j     = {instr[31], instr[19:12],
                    instr[20], instr[30:21]};

  // Select the extended field; first matching bit from the MSB wins.
  always_comb begin
    imm_out = 32'd0;
    case (1'b1)
      ext_op[5]: imm_out = {27'd0, f_shamt};
      ext_op[4]: imm_out = {{20{f_i[11]}}, f_i};
      ext_op[3]: imm_out = {{20{f_s[11]}}, f_s};
      ext_op[2]: imm_out = {{19{f_b[11]}}, f_b, 1'b0};
      ext_op[1]: imm_out = {f_u, 12'd0};
      ext_op[0]: imm_out = {{11{f_j[19]}}, f_j, 1'b0};
      default:   imm_out = 32'd0;
    endcase
  end

endmodule

// File: rtl/pc_next_ext_unit.sv
// PC register, next-PC select and immediate generation.
// The PC is the only state; everything else is combinational.
module pc_next_ext_unit
  import pc_next_ext_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic [31:0] instr,
  input  logic [5:0]  ext_op,
  input  logic [2:0]  npc_op,
  input  logic [31:0] alu_result,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [31:0] pc_plus4,
  output logic [31:0] imm_out
);

  logic [31:0] pc_q;
  logic [31:0] pc_rel;

  imm_ext_unit u_imm (
    .instr   (instr),
    .ext_op  (ext_op),
    .imm_out (imm_out)
  );

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + PC_STEP;
  assign pc_rel   = pc_q + imm_out;

  // Next-PC select; unknown codes fall through to sequential fetch.
  always_comb begin
    npc = pc_plus4;
    case (npc_op)
      NPC_PLUS4:  npc = pc_plus4;
      NPC_BRANCH: npc = pc_rel;
      NPC_JUMP:   npc = pc_rel;
      NPC_JALR:   npc = {alu_result[31:1], 1'b0};
      default:    npc = pc_plus4;
    endcase
  end

  // PC register: reset beats hold, hold freezes fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (!hold) begin
      pc_q <= npc;
    end
  end

endmodule

// File: tb/tb_pc_next_ext_unit.sv
// Self-checking bench for pc_next_ext_unit.
// Directed literal checks followed by randomized traffic against a model.
module tb_pc_next_ext_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic [31:0] instr;
  logic [5:0]  ext_op;
  logic [2:0]  npc_op;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] pc_plus4;
  logic [31:0] imm_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_pc;
  bit          m_ok = 1'b0;

  pc_next_ext_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .instr      (instr),
    .ext_op     (ext_op),
    .npc_op     (npc_op),
    .alu_result (alu_result),
    .pc         (pc),
    .npc        (npc),
    .pc_plus4   (pc_plus4),
    .imm_out    (imm_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_imm(
    input logic [31:0] i, input logic [5:0] op);
    logic signed [11:0] v12;
    logic signed [12:0] v13;
    logic signed [20:0] v21;
    if (op[5]) return 32'(i[24:20]);
    if (op[4]) begin
      v12 = i[31:20];
      return 32'(v12);
    end
    if (op[3]) begin
      v12 = {i[31:25], i[11:7]};
      return 32'(v12);
    end
    if (op[2]) begin
      v13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
      return 32'(v13);
    end
    if (op[1]) return i & 32'hFFFF_F000;
    if (op[0]) begin
      v21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
      return 32'(v21);
    end
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_npc(
    input logic [31:0] p, input logic [2:0] op,
    input logic [31:0] imm, input logic [31:0] alu);
    if (op == 3'd1 || op == 3'd2) return p + imm;
    if (op == 3'd4) return alu - 32'(alu[0]);
    return p + 32'd4;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model PC follows the same edge as the DUT.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_pc <= RST_PC;
      m_ok <= 1'b1;
    end else if (m_ok && hold === 1'b0) begin
      m_pc <= m_npc(m_pc, npc_op,
                    m_imm(instr, ext_op), alu_result);
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (m_ok) begin
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("imm_out", imm_out, m_imm(instr, ext_op));
      check("npc", npc, m_npc(m_pc, npc_op,
            m_imm(instr, ext_op), alu_result));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    hold       = 1'b0;
    instr      = 32'd0;
    ext_op     = 6'd0;
    npc_op     = 3'd0;
    alu_result = 32'd0;
    step();
    rst = 1'b0;
    #1 check("lit_reset_pc", pc, 32'h0);
    step(); check("lit_seq1", pc, 32'h4);
    step(); check("lit_seq2", pc, 32'h8);
    hold = 1'b1;
    step(); check("lit_hold1", pc, 32'h8);
    step(); check("lit_hold2", pc, 32'h8);
    hold = 1'b0;
    step(); check("lit_seq3", pc, 32'hC);
    check("lit_plus4", pc_plus4, 32'h10);
    rst = 1'b1; hold = 1'b1;
    step(); check("lit_rst_hold", pc, 32'h0);
    rst = 1'b0; hold = 1'b0;
    repeat (4) step();
    check("lit_pc10", pc, 32'h10);

    instr = 32'hFE000CE3; ext_op = 6'b000100; npc_op = 3'b001;
    #1 check("lit_b_imm", imm_out, 32'hFFFF_FFF8);
    check("lit_b_npc", npc, 32'h8);
    step(); check("lit_b_pc", pc, 32'h8);

    npc_op = 3'b000; hold = 1'b1;
    instr = 32'hFFF00093; ext_op = 6'b010000;
    #1 check("lit_i_imm", imm_out, 32'hFFFF_FFFF);
    instr = 32'h00202223; ext_op = 6'b001000;
    #1 check("lit_s_imm", imm_out, 32'h4);
    instr = 32'h12345037; ext_op = 6'b000010;
    #1 check("lit_u_imm", imm_out, 32'h1234_5000);
    instr = 32'h00309093; ext_op = 6'b100000;
    #1 check("lit_sh_imm", imm_out, 32'h3);
    ext_op = 6'b000000;
    #1 check("lit_zero_imm", imm_out, 32'h0);
    ext_op = 6'b011000;
    #1 check("lit_multi_hot", imm_out, 32'h3);
    hold = 1'b0;

    npc_op = 3'b100; alu_result = 32'h20;
    step(); check("lit_jalr_pc", pc, 32'h20);
    instr = 32'h010000EF; ext_op = 6'b000001; npc_op = 3'b010;
    #1 check("lit_j_imm", imm_out, 32'h10);
    check("lit_jal_npc", npc, 32'h30);
    check("lit_jal_link", pc_plus4, 32'h24);
    npc_op = 3'b100; alu_result = 32'h0000_0105;
    #1 check("lit_jalr_npc", npc, 32'h104);

    alu_result = 32'hFFFF_FFFD;
    step(); check("lit_top_pc", pc, 32'hFFFF_FFFC);
    npc_op = 3'b000;
    #1 check("lit_wrap_npc", npc, 32'h0);
    npc_op = 3'b011;
    #1 check("lit_illegal_npc", npc, 32'h0);
    step(); check("lit_wrap_pc", pc, 32'h0);

    for (int k = 0; k < 600; k++) begin
      int sel;
      instr      = $urandom;
      alu_result = $urandom;
      npc_op     = 3'($urandom_range(0, 7));
      hold       = ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 49) == 0);
      sel        = $urandom_range(0, 8);
      if (sel < 6) ext_op = 6'(1 << sel);
      else if (sel == 6) ext_op = 6'd0;
      else ext_op = 6'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
